// File: rtl/hls_deadlock_monitor_param_pkg.sv
// Purpose : shared definitions for the HLS deadlock monitor slice:
//           the filter state encoding, a clog2 helper that never returns
//           zero, and the default persistence length.
// Contents: monitor_state_t, clog2_min1(), DEFAULT_PERSIST
package hls_deadlock_pkg;

    // Filter states: no stall seen, stall seen but not yet persistent,
    // persistent stall reported as deadlock.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_BLOCKED = 2'd2
    } monitor_state_t;

    localparam int DEFAULT_PERSIST = 1;

    // $clog2 clamped to at least 1 so counters never collapse to zero width.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/hls_deadlock_monitor_param_if.sv
// Purpose : bundles the monitor's flag inputs, controls and status outputs.
// Modports: master - environment side (drives flags/controls, reads status)
//           slave  - monitor side (reads flags/controls, drives status)
// Signals : axis_block_sigs[N_AXIS], inst_idle_sigs[N_INST],
//           inst_block_sigs[N_INST], sub_block[max(N_SUB,1)], enable, clear,
//           block, block_sticky, block_cause[N_AXIS], event_count[CNT_W]
interface hls_deadlock_monitor_param_if #(
    parameter int N_AXIS = 3,
    parameter int N_INST = 2,
    parameter int N_SUB  = 1,
    parameter int CNT_W  = 16
);
    localparam int SUB_W = (N_SUB > 0) ? N_SUB : 1;

    logic [N_AXIS-1:0] axis_block_sigs;
    logic [N_INST-1:0] inst_idle_sigs;
    logic [N_INST-1:0] inst_block_sigs;
    logic [SUB_W-1:0]  sub_block;
    logic              enable;
    logic              clear;
    logic              block;
    logic              block_sticky;
    logic [N_AXIS-1:0] block_cause;
    logic [CNT_W-1:0]  event_count;

    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs, sub_block,
               enable, clear,
        input  block, block_sticky, block_cause, event_count
    );

    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, sub_block,
               enable, clear,
        output block, block_sticky, block_cause, event_count
    );

endinterface

// File: rtl/hls_deadlock_monitor_param_persist_filter.sv
// Purpose : persistence filter for the deadlock condition. The condition must
//           hold for PERSIST consecutive cycles before blocked asserts.
// Ports   : clock, reset (sync, active-high), cond, clear, enable inputs;
//           blocked (registered state==BLOCKED), enter_blocked (one-cycle
//           pulse, high in the cycle whose edge moves the FSM into BLOCKED)
module deadlock_persist_filter
    import hls_deadlock_pkg::*;
#(
    parameter int PERSIST = DEFAULT_PERSIST,
    parameter int STICKY  = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic cond,
    input  logic clear,
    input  logic enable,
    output logic blocked,
    output logic enter_blocked
);
    localparam int                PCNT_W       = clog2_min1(PERSIST + 1);
    localparam logic [PCNT_W-1:0] PERSIST_LAST = PCNT_W'(PERSIST - 1);

    monitor_state_t    state, state_next;
    logic [PCNT_W-1:0] pcnt, pcnt_next;

    // State and persistence counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            pcnt  <= '0;
        end else begin
            state <= state_next;
            pcnt  <= pcnt_next;
        end
    end

    // Next-state logic. clear and a disabled monitor both pull the FSM back
    // to IDLE before any detection is considered, so clear wins over a
    // same-cycle detection. pcnt holds the number of edges the condition has
    // been seen so far, so SUSPECT commits once pcnt reaches PERSIST-1.
    always_comb begin
        state_next    = state;
        pcnt_next     = pcnt;
        enter_blocked = 1'b0;
        if (clear || !enable) begin
            state_next = ST_IDLE;
            pcnt_next  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pcnt_next = '0;
                    if (cond) begin
                        if (PERSIST == 1) begin
                            state_next    = ST_BLOCKED;
                            enter_blocked = 1'b1;
                        end else begin
                            state_next = ST_SUSPECT;
                            pcnt_next  = PCNT_W'(1);
                        end
                    end
                end
                ST_SUSPECT: begin
                    if (!cond) begin
                        state_next = ST_IDLE;
                        pcnt_next  = '0;
                    end else if (pcnt == PERSIST_LAST) begin
                        state_next    = ST_BLOCKED;
                        enter_blocked = 1'b1;
                        pcnt_next     = '0;
                    end else begin
                        pcnt_next = pcnt + PCNT_W'(1);
                    end
                end
                ST_BLOCKED: begin
                    pcnt_next = '0;
                    if (STICKY == 0 && !cond) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    pcnt_next  = '0;
                end
            endcase
        end
    end

    assign blocked = (state == ST_BLOCKED);

endmodule

// File: rtl/hls_deadlock_monitor_param.sv
// Purpose : deadlock monitor for one HLS layer instance. Reduces stream,
//           process and child-monitor flags into a deadlock condition,
//           filters it for persistence and records cause, sticky flag and a
//           saturating detection count. block can feed a parent monitor's
//           sub_block input for hierarchical chaining.
// Ports   : clock, reset (sync, active-high); mon (slave modport) carrying
//           axis_block_sigs, inst_idle_sigs, inst_block_sigs, sub_block,
//           enable, clear in and block, block_sticky, block_cause,
//           event_count out
module hls_deadlock_monitor_param
    import hls_deadlock_pkg::*;
#(
    parameter int N_AXIS  = 3,
    parameter int N_INST  = 2,
    parameter int N_SUB   = 1,
    parameter int PERSIST = DEFAULT_PERSIST,
    parameter int STICKY  = 0,
    parameter int CNT_W   = 16
) (
    input logic                          clock,
    input logic                          reset,
    hls_deadlock_monitor_param_if.slave  mon
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              any_axis, any_sub, any_inst, all_idle, cond;
    logic              blocked, enter_blocked;
    logic              sticky_q;
    logic [N_AXIS-1:0] cause_q;
    logic [CNT_W-1:0]  count_q;

    // A process only counts as blocked when it is not also idle; a layer
    // whose processes are all idle is never deadlocked.
    assign any_axis = |mon.axis_block_sigs;
    assign any_inst = |(mon.inst_block_sigs & ~mon.inst_idle_sigs);
    assign all_idle = &mon.inst_idle_sigs;

    generate
        if (N_SUB > 0) begin : g_sub
            assign any_sub = |mon.sub_block;
        end else begin : g_no_sub
            assign any_sub = 1'b0;
        end
    endgenerate

    assign cond = mon.enable & ~all_idle & any_axis & (any_sub | any_inst);

    deadlock_persist_filter #(
        .PERSIST (PERSIST),
        .STICKY  (STICKY)
    ) u_filter (
        .clock         (clock),
        .reset         (reset),
        .cond          (cond),
        .clear         (mon.clear),
        .enable        (mon.enable),
        .blocked       (blocked),
        .enter_blocked (enter_blocked)
    );

    // Detection records: snapshot the stalled channels only on entry into
    // BLOCKED, so later stream activity does not blur the original cause.
    // clear wipes the records but deliberately keeps the event counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            sticky_q <= 1'b0;
            cause_q  <= '0;
            count_q  <= '0;
        end else if (mon.clear) begin
            sticky_q <= 1'b0;
            cause_q  <= '0;
        end else if (enter_blocked) begin
            sticky_q <= 1'b1;
            cause_q  <= mon.axis_block_sigs;
            if (count_q != CNT_MAX) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign mon.block        = blocked;
    assign mon.block_sticky = sticky_q;
    assign mon.block_cause  = cause_q;
    assign mon.event_count  = count_q;

endmodule

// File: doc/hls_deadlock_monitor_param.md
Name: hls_deadlock_monitor_param

Overview:
Parametrised deadlock monitor for one HLS-generated FINN layer instance (MVAU/VVAU/SWG class). It combines per-channel AXI-stream block flags, per-process idle/block flags and child-monitor block flags into a deadlock condition. A persistence filter rejects transient stalls. It reports a registered block flag, a sticky flag, a captured cause vector and a saturating detection count, and it chains hierarchically like the per-instance monitors it replaces.

Parameters:
N_AXIS, 3, number of AXI-stream channels monitored (>=1)
N_INST, 2, number of sub-process idle/block signal pairs (>=1)
N_SUB, 1, number of child monitor block inputs (>=0; 0 disables the sub path)
PERSIST, 1, consecutive cycles the condition must hold before block asserts (>=1)
STICKY, 0, 1 = block holds until clear; 0 = block follows the condition
CNT_W, 16, width of the detection event counter

Ports:
clock  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
axis_block_sigs  in  N_AXIS  per-channel stream stall (full/empty while accessed)
inst_idle_sigs  in  N_INST  per-process idle
inst_block_sigs  in  N_INST  per-process blocked-on-handshake
sub_block  in  max(N_SUB,1)  block outputs of child monitors (ignored if N_SUB=0)
enable  in  1  0 = monitor frozen in IDLE, no detection
clear  in  1  clears block, block_sticky, cause; counter kept
block  out  1  deadlock detected (registered)
block_sticky  out  1  set on first detection, held until clear/reset
block_cause  out  N_AXIS  axis_block_sigs snapshot at detection
event_count  out  CNT_W  number of IDLE/SUSPECT->BLOCKED transitions, saturating

Behaviour:
- Reset: all outputs 0; state IDLE; persistence counter 0.
- Combinational condition:
  any_axis = |axis_block_sigs.
  any_sub = |sub_block when N_SUB>0, else 0.
  any_inst = |(inst_block_sigs & ~inst_idle_sigs).
  all_idle = &inst_idle_sigs.
  cond = enable & ~all_idle & any_axis & (any_sub | any_inst).
- Persistence counter pcnt, width $clog2(PERSIST+1):
  - Increments while cond=1 and state != BLOCKED.
  - Resets to 0 on any cycle with cond=0.
- FSM states IDLE, SUSPECT, BLOCKED:
  - IDLE: cond=1 and PERSIST=1 -> BLOCKED. cond=1 and PERSIST>1 -> SUSPECT with pcnt=1.
  - SUSPECT: cond=0 -> IDLE. Otherwise pcnt+1==PERSIST -> BLOCKED.
  - BLOCKED, STICKY=0: cond=0 -> IDLE.
  - BLOCKED, STICKY=1: leave only on clear or reset, then -> IDLE.
- Latency: cond first high at cycle t and held -> block=1 from cycle t+PERSIST. With PERSIST=1 this is a one-cycle registered response.
- block = (state==BLOCKED), registered.
- block_cause loads axis_block_sigs on the IDLE/SUSPECT->BLOCKED edge only and holds while BLOCKED. It is not updated by later axis changes.
- block_sticky sets on the same edge and is held regardless of STICKY.
- event_count increments on each entry into BLOCKED and saturates at all-ones.
- clear has priority over detection in the same cycle:
  - state -> IDLE, pcnt -> 0; block, block_sticky, block_cause -> 0.
  - If cond is still 1, re-detection starts on the next cycle.
- enable=0: state forced to IDLE, pcnt=0, block=0; sticky, cause and counter retained.
- Reset mid-SUSPECT or mid-BLOCKED returns everything to reset values on the next edge.
- all_idle=1 is never a deadlock, even with axis stalls present.

Decomposition:
- Package hls_deadlock_pkg: state enum (IDLE/SUSPECT/BLOCKED), function clog2_min1, default PERSIST.
- One sub-module, deadlock_persist_filter: holds the counter plus FSM, with inputs cond/clear/enable and outputs blocked/enter_blocked. The top level reduces the condition and holds the cause/sticky/count registers.

Test Plan:
- PERSIST=1, N_SUB=1: sub_block=1 and axis=3'b010 at cycle 5 -> block=1 at cycle 6, cause=3'b010, event_count=1. Drop cond -> block=0 next cycle.
- PERSIST=4: cond high 3 cycles then low -> block never asserts, event_count=0. Cond high 4 cycles -> block=1 exactly 4 cycles after first assertion.
- STICKY=1: detect, then drop cond -> block stays 1. Pulse clear -> block=0, block_sticky=0, cause=0 next cycle, event_count unchanged.
- inst_idle=2'b11 with axis=3'b111 and inst_block=1 -> cond=0, block stays 0. inst_idle=2'b01, inst_block=2'b10, axis=001 -> detection.
- CNT_W=2: 5 detection/release cycles -> event_count saturates at 3.
- Reset asserted while in SUSPECT and while BLOCKED -> all outputs 0 next edge. clear and cond both high -> IDLE that cycle, BLOCKED again PERSIST cycles later.
